uart_tx_sequencer: RTL and testbench

Frame sequencer for the UART transmit path. Accepts a byte over a valid/ready handshake, then drives the serial line one bit period at a time: start bit, 8 data bits LSB first, optional parity, stop bit(s). It contains its own bit-period counter, which runs only while a frame is in flight and restarts on every accepted byte, so bit boundaries are aligned to the accept edge. It sits between the byte source (FIFO or host logic) and the TX pin, in the transmit clock domain.

---
 rtl/uart_tx_sequencer_if.sv | 25 ++
 rtl/uart_tx_sequencer.sv | 127 ++++++++++++
 tb/tb_uart_tx_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_sequencer_if.sv
// Byte-in / serial-out handshake bundle for the UART transmit sequencer.
// master = byte source side, slave = sequencer side.
interface uart_tx_sequencer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       txd;
    logic       tx_busy;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  txd,
        input  tx_busy
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output txd,
        output tx_busy
    );
endinterface

// File: rtl/uart_tx_sequencer.sv
// UART transmit frame sequencer: start, 8 data bits LSB first, optional even parity, stop bit(s).
// Define UART_TX_PARITY_EN to compile in the even-parity bit after D7.
module uart_tx_sequencer #(
    parameter int BAUD_RATE = 115200,
    parameter int FRQ       = 50000000,
    parameter int CLK_DIV   = FRQ / BAUD_RATE,
    parameter int STOP_BITS = 1
) (
    input  logic                  clk1,
    input  logic                  rst,
    uart_tx_sequencer_if.slave    tx_if
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [2:0]      idx_q;
    logic [7:0]      data_q;
    logic            txd_q;
    logic            ready_q;
    logic            cnt_last;

    // The bit counter restarts at the accept edge, so every bit boundary is
    // a whole number of CLK_DIV periods after it.
    assign cnt_last = (cnt_q == CW'(CLK_DIV - 1));
    assign cnt_d    = cnt_last ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            txd_q   <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            if (state_q != S_IDLE) begin
                cnt_q <= cnt_d;
            end

            case (state_q)
                S_IDLE: begin
                    if (tx_if.tx_valid && ready_q) begin
                        data_q  <= tx_if.tx_data;
                        state_q <= S_START;
                        txd_q   <= 1'b0;
                        ready_q <= 1'b0;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end
                end

                S_START: begin
                    if (cnt_last) begin
                        state_q <= S_DATA;
                        txd_q   <= data_q[0];
                        idx_q   <= '0;
                    end
                end

                S_DATA: begin
                    if (cnt_last) begin
                        if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= S_PARITY;
                            txd_q   <= ^data_q;
`else
                            state_q <= S_STOP;
                            txd_q   <= 1'b1;
`endif
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                            txd_q <= data_q[idx_q + 3'd1];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (cnt_last) begin
                        state_q <= S_STOP;
                        txd_q   <= 1'b1;
                        idx_q   <= '0;
                    end
                end
`endif

                S_STOP: begin
                    // idx_q counts stop bits here; each one is a full CLK_DIV period.
                    if (cnt_last) begin
                        if (idx_q == 3'(STOP_BITS - 1)) begin
                            state_q <= S_IDLE;
                            ready_q <= 1'b1;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    txd_q   <= 1'b1;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign tx_if.txd      = txd_q;
    assign tx_if.tx_ready = ready_q;
    assign tx_if.tx_busy  = ~ready_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench for uart_tx_sequencer: stimulus pushes per-cycle expected line/ready
// values, a negedge monitor pops and compares them. Two instances: 1 and 2 stop bits.
module tb_uart_tx_sequencer;

    localparam int D = 10;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef struct {
        int    cyc;
        int    dut;
        logic  txd;
        logic  rdy;
        string name;
    } exp_t;

    logic clk1;
    logic rst;
    int   edge_cnt = 0;
    int   checks   = 0;
    int   errors   = 0;
    exp_t exp_q[$];

    uart_tx_sequencer_if if1 ();
    uart_tx_sequencer_if if2 ();

    uart_tx_sequencer #(.BAUD_RATE(100), .FRQ(1000), .STOP_BITS(1)) dut1 (
        .clk1  (clk1),
        .rst   (rst),
        .tx_if (if1)
    );

    uart_tx_sequencer #(.BAUD_RATE(100), .FRQ(1000), .STOP_BITS(2)) dut2 (
        .clk1  (clk1),
        .rst   (rst),
        .tx_if (if2)
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    always @(posedge clk1) edge_cnt <= edge_cnt + 1;

    function automatic logic get_txd(input int d);
        return (d == 0) ? if1.txd : if2.txd;
    endfunction

    function automatic logic get_rdy(input int d);
        return (d == 0) ? if1.tx_ready : if2.tx_ready;
    endfunction

    function automatic logic get_busy(input int d);
        return (d == 0) ? if1.tx_busy : if2.tx_busy;
    endfunction

    // Monitor: value visible after posedge N is checked against entries for cycle N.
    always @(negedge clk1) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= edge_cnt) begin
            exp_t e;
            logic a_txd, a_rdy, a_busy;
            e      = exp_q.pop_front();
            a_txd  = get_txd(e.dut);
            a_rdy  = get_rdy(e.dut);
            a_busy = get_busy(e.dut);
            checks++;
            if (e.cyc != edge_cnt || a_txd !== e.txd || a_rdy !== e.rdy || a_busy !== ~e.rdy) begin
                errors++;
                $display("FAIL %s dut%0d cyc=%0d(at %0d) txd=%b want %b ready=%b want %b busy=%b want %b",
                         e.name, e.dut, e.cyc, edge_cnt, a_txd, e.txd, a_rdy, e.rdy, a_busy, ~e.rdy);
            end
        end
    end

    task automatic push(input int cyc, input int d, input logic t, input logic r, input string name);
        exp_t e;
        e.cyc = cyc; e.dut = d; e.txd = t; e.rdy = r; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic set_in(input int d, input logic [7:0] b, input logic v);
        if (d == 0) begin if1.tx_data = b; if1.tx_valid = v; end
        else        begin if2.tx_data = b; if2.tx_valid = v; end
    endtask

    // Called #1 after a posedge. Waits for ready, records accept edge k and pushes the frame.
    task automatic send(input int d, input logic [7:0] b, input logic par, input int nstop,
                        input bit hold, input int trunc, input string name, output int k);
        int guard;
        int nb;
        int slot;
        logic t;
        guard = 0;
        set_in(d, b, 1'b1);
        while (get_rdy(d) !== 1'b1 && guard < 500) begin
            @(posedge clk1); #1;
            guard++;
        end
        if (guard >= 500) begin
            checks++; errors++;
            $display("FAIL %s_ready_timeout ready=%b want 1", name, get_rdy(d));
        end
        k  = edge_cnt + 1;
        nb = 10 + nstop - 1 + PAR;
        for (int off = 0; off <= nb * D; off++) begin
            if (trunc > 0 && off >= trunc) begin
                push(k + off, d, 1'b1, 1'b1, {name, "_rst"});
                break;
            end
            slot = off / D;
            if (slot == 0)                   t = 1'b0;
            else if (slot <= 8)              t = b[slot-1];
            else if (slot == 9 && PAR == 1)  t = par;
            else                             t = 1'b1;
            push(k + off, d, t, (off == nb * D), name);
        end
        $display("tx dut%0d byte=0x%02h accept_edge=%0d frame_bits=%0d %s", d, b, k, nb, name);
        @(posedge clk1); #1;
        // Mid-frame data change must not reach the line.
        set_in(d, ~b, hold);
    endtask

    task automatic drain(input string name);
        int g;
        g = 0;
        while (exp_q.size() > 0 && g < 3000) begin
            @(posedge clk1); #1;
            g++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending=%0d want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int k;
        rst = 1'b1;
        set_in(0, 8'h00, 1'b0);
        set_in(1, 8'h00, 1'b0);

        // Reset held 3 cycles, then 50 idle cycles with tx_valid low.
        for (int c = 1; c <= 53; c++) begin
            push(c, 0, 1'b1, 1'b1, "reset_idle");
            push(c, 1, 1'b1, 1'b1, "reset_idle");
        end
        repeat (3) @(posedge clk1);
        #1 rst = 1'b0;
        repeat (50) @(posedge clk1);
        #1;
        drain("reset_idle");

        send(0, 8'hA5, 1'b0, 1, 1'b0, 0, "byte_a5", k);
        drain("byte_a5");

        send(0, 8'h07, 1'b1, 1, 1'b0, 0, "par_07", k);
        drain("par_07");
        send(0, 8'h03, 1'b0, 1, 1'b0, 0, "par_03", k);
        drain("par_03");

        // Back-to-back with tx_valid held high.
        send(0, 8'h55, 1'b0, 1, 1'b1, 0, "b2b_55", k);
        send(0, 8'h0F, 1'b0, 1, 1'b0, 0, "b2b_0f", k);
        drain("b2b");

        send(1, 8'hFF, 1'b0, 2, 1'b0, 0, "stop2_ff", k);
        drain("stop2_ff");

        // Reset wins over an accept on the same edge.
        k = edge_cnt;
        set_in(0, 8'h3C, 1'b1);
        rst = 1'b1;
        push(k + 1, 0, 1'b1, 1'b1, "rst_prio");
        push(k + 1, 1, 1'b1, 1'b1, "rst_prio");
        push(k + 2, 0, 1'b1, 1'b1, "rst_prio");
        @(posedge clk1); #1;
        rst = 1'b0;
        set_in(0, 8'h3C, 1'b0);
        drain("rst_prio");

        // Reset in the middle of a frame at accept+45.
        send(0, 8'hC3, 1'b0, 1, 1'b0, 45, "midrst_c3", k);
        while (edge_cnt < k + 44) begin
            @(posedge clk1); #1;
        end
        rst = 1'b1;
        @(posedge clk1); #1;
        rst = 1'b0;
        drain("midrst_c3");

        send(0, 8'h81, 1'b0, 1, 1'b0, 0, "after_rst_81", k);
        drain("after_rst_81");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
